// File: rtl/spram_pkg.sv
// Shared types and helpers for the byte-lane single-port RAM.
//   acc_sz_t   : access size encoding on the sz port
//   state_t    : controller states
//   lane_count : number of bytes an access touches, with size clamped to the
//                full data width
package spram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_sz_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Sizes above log2(lanes) clamp to a full-width access.
  function automatic int unsigned lane_count(input logic [1:0] sz,
                                             input int unsigned lb);
    int unsigned s;
    s = (32'(sz) > lb) ? lb : 32'(sz);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/spram_lane.sv
// One 8-bit bank of the byte-lane RAM.
//   clk  : clock
//   we   : write enable for this lane
//   addr : word address
//   wd   : write byte
//   rd   : registered read byte (old contents on a same-cycle write)
module spram_lane #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);

  logic [7:0] mem [2**AW];

  // NOTE: the array has no reset; clearing it would need a loop over every
  // word and would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/spram_bl.sv
// Byte-lane single-port RAM with byte/half/word access at any alignment.
// Accesses crossing a word boundary take two bank cycles.
//   clk : clock               rst : synchronous active-high reset
//   req : request valid       rdy : request can be accepted this cycle
//   we  : 1 write / 0 read    sz  : 0 byte, 1 half, 2 word (larger clamps)
//   ai  : byte address        vi  : write data, byte k at vi[8k+:8]
//   ack : one-cycle completion pulse
//   vo  : read data during ack on reads, else zero
module spram_bl
  import spram_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           rdy,
  input  logic           we,
  input  logic [1:0]     sz,
  input  logic [ASZ-1:0] ai,
  input  logic [DSZ-1:0] vi,
  output logic           ack,
  output logic [DSZ-1:0] vo
);

  localparam int NB = DSZ / 8;
  localparam int LB = $clog2(NB);
  localparam int WA = ASZ - LB;

  // Request decode
  logic [LB-1:0] o_in;
  logic [WA-1:0] w0_in;
  logic [LB:0]   n_in;
  logic          split_in;
  logic          accept;

  assign o_in     = ai[LB-1:0];
  assign w0_in    = ai[ASZ-1:LB];
  assign n_in     = (LB+1)'(lane_count(sz, LB));
  assign split_in = ({1'b0, o_in} + n_in) > (LB+1)'(NB);
  assign accept   = req && rdy;

  // FSM
  state_t state, state_nx;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: default first so no path leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && split_in) state_nx = SPLIT;
      SPLIT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy = (state == IDLE);
  end

  // Transfer context: latched on accept, drives the second half of a split
  // and the read assembly during ack.
  logic           cur_we;
  logic [LB:0]    cur_n;
  logic [LB-1:0]  cur_o;
  logic [WA-1:0]  cur_w1;
  logic [DSZ-1:0] cur_vi;
  logic           rsp_split;
  logic [DSZ-1:0] bank_q;
  logic [DSZ-1:0] hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      rsp_split <= 1'b0;
      cur_we    <= 1'b0;
      cur_n     <= '0;
      cur_o     <= '0;
      cur_w1    <= '0;
      cur_vi    <= '0;
    end else begin
      ack       <= (accept && !split_in) || (state == SPLIT);
      rsp_split <= (state == SPLIT);
      if (accept) begin
        cur_we <= we;
        cur_n  <= n_in;
        cur_o  <= o_in;
        cur_w1 <= w0_in + WA'(1);
        cur_vi <= vi;
      end
    end
  end

  // The SPLIT-cycle access overwrites every lane's read register, so the
  // first-half bytes are parked here. Pure data, never needs a reset.
  always_ff @(posedge clk) begin
    if (state == SPLIT) hold <= bank_q;
  end

  // Bank access for the current phase: the first half (lanes >= o) at w0 in
  // IDLE, the wrapped lanes (< o) at w0+1 in SPLIT. A reset in SPLIT drops
  // the second-half write.
  logic [LB-1:0]  ph_o;
  logic [LB:0]    ph_n;
  logic           ph_we;
  logic [DSZ-1:0] ph_vi;
  logic [WA-1:0]  ph_addr;
  logic           ph_go;
  logic           ph_second;
  logic [LB-1:0]  lane_k  [NB];
  logic [NB-1:0]  lane_we;
  logic [7:0]     lane_wd [NB];

  always_comb begin
    if (state == SPLIT) begin
      ph_o      = cur_o;
      ph_n      = cur_n;
      ph_we     = cur_we;
      ph_vi     = cur_vi;
      ph_addr   = cur_w1;
      ph_go     = !rst;
      ph_second = 1'b1;
    end else begin
      ph_o      = o_in;
      ph_n      = n_in;
      ph_we     = we;
      ph_vi     = vi;
      ph_addr   = w0_in;
      ph_go     = accept && !rst;
      ph_second = 1'b0;
    end
  end

  always_comb begin
    for (int l = 0; l < NB; l++) begin
      lane_k[l]  = LB'(l) - ph_o;  // byte index landing in lane l
      lane_we[l] = ph_go && ph_we && ((LB+1)'(lane_k[l]) < ph_n) &&
                   ((LB'(l) >= ph_o) != ph_second);
      lane_wd[l] = ph_vi[{lane_k[l], 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    spram_lane #(.AW(WA)) u_lane (
      .clk  (clk),
      .we   (lane_we[g]),
      .addr (ph_addr),
      .wd   (lane_wd[g]),
      .rd   (bank_q[8*g +: 8])
    );
  end

  // Read assembly: byte k lives in lane (o+k); after a split, lanes >= o
  // hold first-half data in the hold register.
  logic [LB-1:0] rd_lane [NB];
  logic [7:0]    rd_byte [NB];

  always_comb begin
    vo = '0;
    for (int k = 0; k < NB; k++) begin
      rd_lane[k] = cur_o + LB'(k);
      rd_byte[k] = (rsp_split && rd_lane[k] >= cur_o) ?
                   hold[{rd_lane[k], 3'b000} +: 8] :
                   bank_q[{rd_lane[k], 3'b000} +: 8];
      if (ack && !cur_we && ((LB+1)'(k) < cur_n)) vo[8*k +: 8] = rd_byte[k];
    end
  end

endmodule

// File: tb/tb_spram_bl.sv
module tb_spram_bl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rdy;
  logic        we;
  logic [1:0]  sz;
  logic [16:0] ai;
  logic [31:0] vi;
  logic        ack;
  logic [31:0] vo;

  spram_bl #(.ASZ(17), .DSZ(32)) dut (
    .clk (clk), .rst (rst), .req (req), .rdy (rdy), .we (we),
    .sz  (sz),  .ai  (ai),  .vi  (vi),  .ack (ack), .vo (vo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Flat byte-addressed reference memory; little-endian bytes at a+k.
  logic [7:0] mem_m [131072];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [16:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = mem_m[17'(a + 17'(k))];
    return r;
  endfunction

  task automatic model_wr(input logic [16:0] a, input int n,
                          input logic [31:0] d);
    for (int k = 0; k < n; k++) mem_m[17'(a + 17'(k))] = d[8*k +: 8];
  endtask

  // One transfer; returns the data seen while ack is high, accept-to-ack
  // latency, and rdy right after the accepting edge.
  task automatic access(input bit w, input logic [1:0] s, input logic [16:0] a,
                        input logic [31:0] d, output logic [31:0] q,
                        output int lat, output logic rdy_after);
    int waitc;
    waitc = 0;
    req = 1'b1; we = w; sz = s; ai = a; vi = d;
    while (!rdy && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc == 10) check("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rdy_after = rdy;
    req = 1'b0;
    lat = 1;
    while (!ack && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ack) check("ack_timeout", 32'd0, 32'd1);
    q = vo;
    @(posedge clk); #1;
    check("ack_pulse", 32'(ack), 32'd0);
  endtask

  task automatic op(input string tag, input bit w, input logic [1:0] s,
                    input logic [16:0] a, input logic [31:0] d,
                    output logic [31:0] q);
    int n, lat;
    bit spl;
    logic rdy_after;
    logic [31:0] exp;
    n   = (s >= 2) ? 4 : (1 << s);
    spl = (int'(a[1:0]) + n) > 4;
    exp = w ? 32'h0 : model_rd(a, n);
    access(w, s, a, d, q, lat, rdy_after);
    check({tag, "_lat"}, 32'(lat), spl ? 32'd2 : 32'd1);
    check({tag, "_rdy"}, 32'(rdy_after), 32'(!spl));
    check({tag, "_vo"}, q, exp);
    if (w) model_wr(a, n, d);
  endtask

  initial begin
    logic [31:0] q;
    logic [16:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    bit          w;

    for (int i = 0; i < 131072; i++) mem_m[i] = 8'h00;
    rst = 1'b1; req = 1'b0; we = 1'b0; sz = 2'd0; ai = '0; vi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_vo", vo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero the windows the bench reads from.
    for (int i = 0; i < 64; i++) op("pre_lo", 1'b1, 2'd2, 17'(4*i), 32'h0, q);
    for (int i = 0; i < 64; i++) op("pre_hi", 1'b1, 2'd2, 17'h1FF00 + 17'(4*i), 32'h0, q);

    // Aligned word and byte
    op("aw_wr", 1'b1, 2'd2, 17'h00010, 32'h11223344, q);
    op("aw_rd", 1'b0, 2'd2, 17'h00010, 32'h0, q);
    check("aw_const", q, 32'h11223344);
    op("ab_rd", 1'b0, 2'd0, 17'h00011, 32'h0, q);
    check("ab_const", q, 32'h00000033);

    // Byte-lane isolation
    op("iso_wr", 1'b1, 2'd2, 17'h00020, 32'hAABBCCDD, q);
    op("iso_bw", 1'b1, 2'd0, 17'h00022, 32'h0000005A, q);
    op("iso_rd", 1'b0, 2'd2, 17'h00020, 32'h0, q);
    check("iso_const", q, 32'hAA5ACCDD);

    // Split word
    op("sp_wr", 1'b1, 2'd2, 17'h00033, 32'hDEADBEEF, q);
    for (int k = 0; k < 4; k++) begin
      op("sp_b", 1'b0, 2'd0, 17'h00033 + 17'(k), 32'h0, q);
      d = 32'hDEADBEEF;
      check("sp_b_const", q, {24'h0, d[8*k +: 8]});
    end
    op("sp_h37", 1'b0, 2'd1, 17'h00037, 32'h0, q);
    check("sp_h37_const", q, 32'h0);
    op("sp_b32", 1'b0, 2'd0, 17'h00032, 32'h0, q);
    check("sp_b32_const", q, 32'h0);

    // Top-of-memory wrap
    op("wr_wr", 1'b1, 2'd2, 17'h1FFFE, 32'h01020304, q);
    op("wr_b0", 1'b0, 2'd0, 17'h1FFFE, 32'h0, q); check("wr_b0_c", q, 32'h04);
    op("wr_b1", 1'b0, 2'd0, 17'h1FFFF, 32'h0, q); check("wr_b1_c", q, 32'h03);
    op("wr_b2", 1'b0, 2'd0, 17'h00000, 32'h0, q); check("wr_b2_c", q, 32'h02);
    op("wr_b3", 1'b0, 2'd0, 17'h00001, 32'h0, q); check("wr_b3_c", q, 32'h01);
    op("wr_rd", 1'b0, 2'd2, 17'h1FFFE, 32'h0, q); check("wr_rd_c", q, 32'h01020304);

    // Throughput: 8 back-to-back aligned reads with req held high
    for (int i = 0; i < 8; i++) op("tp_fill", 1'b1, 2'd2, 17'h40 + 17'(4*i), $urandom, q);
    req = 1'b1; we = 1'b0; sz = 2'd2;
    for (int i = 0; i < 8; i++) begin
      ai = 17'h40 + 17'(4*i);
      check("tp_rdy", 32'(rdy), 32'd1);
      @(posedge clk); #1;
      check("tp_ack", 32'(ack), 32'd1);
      check("tp_data", vo, model_rd(17'h40 + 17'(4*i), 4));
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("tp_ack_end", 32'(ack), 32'd0);

    // Reset during the SPLIT cycle of a split write
    op("rs_z0", 1'b1, 2'd2, 17'h00000, 32'h0, q);
    op("rs_z1", 1'b1, 2'd2, 17'h00004, 32'h0, q);
    req = 1'b1; we = 1'b1; sz = 2'd2; ai = 17'h00002; vi = 32'hCAFEBABE;
    @(posedge clk); #1;
    req = 1'b0;
    check("rs_in_split", 32'(rdy), 32'd0);
    check("rs_no_ack0", 32'(ack), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_rdy", 32'(rdy), 32'd1);
    check("rs_ack", 32'(ack), 32'd0);
    check("rs_vo", vo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rs_ack_after", 32'(ack), 32'd0);
    mem_m[2] = 8'hBE;
    mem_m[3] = 8'hBA;
    op("rs_rd0", 1'b0, 2'd2, 17'h00000, 32'h0, q); check("rs_rd0_c", q, 32'hBABE0000);
    op("rs_rd4", 1'b0, 2'd2, 17'h00004, 32'h0, q); check("rs_rd4_c", q, 32'h00000000);

    // Randomized traffic over the zeroed windows
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = 17'h1FF00 + 17'($urandom_range(0, 255));
      else                           a = 17'($urandom_range(0, 248));
      d = $urandom;
      op("rnd", w, s, a, d, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spram_bl.md
Name: spram_bl

Overview:
- Parametrised byte-lane single-port RAM; the next generation of the 8-bit SPRAM.
- Stores little-endian data in NB independent 8-bit lanes.
- Supports byte, half and word accesses at any byte address; accesses that cross a word boundary split into two bank cycles.
- Sits between the eForth core's memory bus and on-chip SPRAM; uses a valid/ready request handshake and an ack response.

Parameters:
ASZ, 17, byte-address width (2^ASZ bytes total)
DSZ, 32, data width; multiple of 8; NB = DSZ/8 must be a power of two (derived localparam, log2 NB = LB)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  request valid
rdy  out  1  controller can accept request this cycle
we  in  1  1 = write, 0 = read
sz  in  2  access size: 0 byte, 1 half, 2 word; values above LB clamp to LB (full width)
ai  in  ASZ  byte address, any alignment
vi  in  DSZ  write data; byte k at vi[8k+:8]
ack  out  1  one-cycle pulse: access complete
vo  out  DSZ  read data, valid only while ack=1 on a read; unused upper bytes are zero

Behaviour:
- Reset is synchronous, active-high, sampled on the clk rising edge. After reset: state=IDLE, rdy=1, ack=0, vo=0. Memory contents are not cleared.
- Transfer occurs on an edge where req && rdy. The requester holds req/we/sz/ai/vi stable until rdy=1.
- Byte mapping:
  - n = 1<<sz bytes; o = ai[LB-1:0]; w0 = ai[ASZ-1:LB].
  - Byte k (0..n-1) goes to lane (o+k) mod NB, at word w0 when o+k < NB, else w0+1.
  - w0+1 wraps modulo 2^(ASZ-LB): the top word wraps to word 0.
- Split detection: split = (o + n > NB).
- States:
  - IDLE, rdy=1. On accept with !split: access w0 on this edge; stay IDLE; ack=1 next cycle. Back-to-back aligned requests run at 1 per cycle.
  - IDLE on accept with split: access the w0 lanes on this edge; latch we, sz, o, w0+1 and vi; go to SPLIT, rdy=0.
  - SPLIT, rdy=0. On the next edge: capture the first-half read bytes into a hold register, access w0+1 for the remaining lanes, then go to IDLE. ack=1 the cycle after.
- Write lane enables come only from bytes within n; no other lane is written.
- Read assembly: vo byte k = lane (o+k) output. First-half bytes come from the hold register, second-half bytes from the bank output. Bytes k >= n read as 0.
- Read latency: aligned = 1 cycle accept→ack; split = 2 cycles.
- ack is 1 for exactly one cycle per transfer and is also raised for writes; vo is 0 on write acks.
- Reset during SPLIT: the second half is aborted and never written; the first-half write (already committed) stays. ack stays 0 and the controller returns to IDLE.
- req deasserted: no access and ack=0. A request arriving while rdy=0 is ignored until accepted.

Decomposition:
- Package spram_pkg:
  - enum acc_sz_t {SZ_B=0, SZ_H=1, SZ_W=2}
  - enum state_t {IDLE, SPLIT}
  - lane-count helper function.
- Sub-module spram_lane:
  - one 8-bit bank, depth 2^(ASZ-LB)
  - synchronous write with enable, registered read
  - instantiated NB times via generate.
- Top level contains the FSM, lane rotation/enable logic and read assembly.

Test Plan:
- Aligned word: write 0x11223344 @0x00010, then read @0x00010 → ack one cycle after each accept; vo=0x11223344. Byte read @0x00011 → vo=0x00000033.
- Byte-lane isolation: write word 0xAABBCCDD @0x00020, byte write 0x5A @0x00022, word read @0x00020 → 0xAA5ACCDD.
- Split word: write 0xDEADBEEF @0x00033 → rdy low 1 cycle, ack 2 cycles after accept. Read bytes @0x33..0x36 → EF, BE, AD, DE. Half read @0x00037 → 0x0000 (unwritten assumption-free: prewrite 0) and surrounding bytes unchanged.
- Wrap: word write 0x01020304 @0x1FFFE → bytes 0x1FFFE=04, 0x1FFFF=03, 0x00000=02, 0x00001=01. Word read @0x1FFFE returns 0x01020304.
- Throughput: 8 consecutive aligned reads with req held high → 8 acks on 8 consecutive cycles, rdy continuously 1, data in order.
- Reset mid-split: pre-fill word 0 and word 1 with 0, split write 0xCAFEBABE @0x00002, assert rst in the SPLIT cycle → ack never pulses. Read @0x00000 → 0xBABE0000; word @0x00004 → 0x00000000. After reset, rdy=1 and vo=0.
